// File: rtl/qpsk_tx_framer.sv
// Frame symbol source for the QPSK modulator: preamble, sync, length, payload, XOR checksum as 2-bit symbols.
// symbol_out is registered and advances one symbol per mod_req edge; s_ready drops when the payload FIFO is full.

module qpsk_tx_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    input  logic         rd_en,
    output logic         rd_vld,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [W-1:0]  mem [DEPTH];

    assign wr_rdy = !((wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]));
    assign rd_vld = (wr_ptr != rd_ptr);
    assign rd_dat = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_vld && wr_rdy) wr_ptr <= wr_ptr + PW'(1);
            if (rd_en && rd_vld)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_vld && wr_rdy) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module qpsk_tx_framer #(
    parameter int          PREAMBLE_SYMS = 16,
    parameter logic [15:0] SYNC_WORD     = 16'hD391,
    parameter int          FIFO_DEPTH    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    output logic       frame_ready,
    input  logic       mod_req,
    output logic [1:0] symbol_out,
    output logic       tx_active,
    output logic       frame_done,
    output logic       underrun_err
);
    localparam int CNT_W = (PREAMBLE_SYMS > 8) ? $clog2(PREAMBLE_SYMS) : 3;
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_SYMS - 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, LEN, PAYLOAD, CKSUM} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [1:0]       sym_nxt;
    logic [7:0]       len_q, len_nxt;
    logic [7:0]       cksum_q, cksum_nxt;
    logic [7:0]       byte_q, byte_nxt;
    logic [7:0]       left_q, left_nxt;
    logic             under_nxt;
    logic             done_nxt;
    logic             want_byte;
    logic             pop;
    logic [15:0]      sync_sh;
    logic             fifo_vld;
    logic [7:0]       fifo_dat;

    function automatic logic [1:0] pick(input logic [7:0] b, input logic [1:0] idx);
        case (idx)
            2'd0:    return b[7:6];
            2'd1:    return b[5:4];
            2'd2:    return b[3:2];
            default: return b[1:0];
        endcase
    endfunction

    qpsk_tx_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst_n  (reset),
        .wr_vld (s_valid),
        .wr_dat (s_data),
        .wr_rdy (s_ready),
        .rd_en  (pop),
        .rd_vld (fifo_vld),
        .rd_dat (fifo_dat)
    );

    assign tx_active   = (state != IDLE);
    assign frame_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sym_nxt   = symbol_out;
        len_nxt   = len_q;
        cksum_nxt = cksum_q;
        byte_nxt  = byte_q;
        left_nxt  = left_q;
        under_nxt = underrun_err;
        done_nxt  = 1'b0;
        want_byte = 1'b0;
        pop       = 1'b0;
        cnt_inc   = cnt + CNT_W'(1);
        sync_sh   = SYNC_WORD << {cnt_inc[2:0], 1'b0};

        case (state)
            IDLE: begin
                if (frame_start) begin
                    state_nxt = PREAMBLE;
                    cnt_nxt   = '0;
                    sym_nxt   = 2'b00;
                    len_nxt   = frame_len;
                    cksum_nxt = 8'h00;
                    under_nxt = 1'b0;
                end
            end
            PREAMBLE: begin
                if (mod_req) begin
                    if (cnt == PRE_LAST) begin
                        state_nxt = SYNC;
                        cnt_nxt   = '0;
                        sym_nxt   = SYNC_WORD[15:14];
                    end else begin
                        cnt_nxt = cnt_inc;
                        sym_nxt = cnt_inc[0] ? 2'b11 : 2'b00;
                    end
                end
            end
            SYNC: begin
                if (mod_req) begin
                    if (cnt[2:0] == 3'd7) begin
                        state_nxt = LEN;
                        cnt_nxt   = '0;
                        sym_nxt   = len_q[7:6];
                    end else begin
                        cnt_nxt = cnt_inc;
                        sym_nxt = sync_sh[15:14];
                    end
                end
            end
            LEN: begin
                if (mod_req) begin
                    if (cnt[1:0] == 2'd3) begin
                        if (len_q == 8'd0) begin
                            state_nxt = CKSUM;
                            cnt_nxt   = '0;
                            sym_nxt   = cksum_q[7:6];
                        end else begin
                            want_byte = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                        sym_nxt = pick(len_q, cnt_inc[1:0]);
                    end
                end
            end
            PAYLOAD: begin
                if (mod_req) begin
                    if (cnt[1:0] == 2'd3) begin
                        if (left_q == 8'd0) begin
                            state_nxt = CKSUM;
                            cnt_nxt   = '0;
                            sym_nxt   = cksum_q[7:6];
                        end else begin
                            want_byte = 1'b1;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                        sym_nxt = pick(byte_q, cnt_inc[1:0]);
                    end
                end
            end
            CKSUM: begin
                if (mod_req) begin
                    if (cnt[1:0] == 2'd3) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        sym_nxt   = 2'b00;
                        done_nxt  = 1'b1;
                    end else begin
                        cnt_nxt = cnt_inc;
                        sym_nxt = pick(cksum_q, cnt_inc[1:0]);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // An empty FIFO leaves state and symbol untouched so the next mod_req retries the pop.
        if (want_byte) begin
            if (fifo_vld) begin
                pop       = 1'b1;
                byte_nxt  = fifo_dat;
                cksum_nxt = cksum_q ^ fifo_dat;
                state_nxt = PAYLOAD;
                cnt_nxt   = '0;
                sym_nxt   = fifo_dat[7:6];
                left_nxt  = (state == LEN) ? (len_q - 8'd1) : (left_q - 8'd1);
            end else begin
                under_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            symbol_out   <= 2'b00;
            len_q        <= 8'h00;
            cksum_q      <= 8'h00;
            byte_q       <= 8'h00;
            left_q       <= 8'h00;
            underrun_err <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            symbol_out   <= sym_nxt;
            len_q        <= len_nxt;
            cksum_q      <= cksum_nxt;
            byte_q       <= byte_nxt;
            left_q       <= left_nxt;
            underrun_err <= under_nxt;
            frame_done   <= done_nxt;
        end
    end
endmodule

// File: tb/tb_qpsk_tx_framer.sv
// Directed bench: a 4-symbol-preamble instance for the short reference frame, a default instance for the rest.
module tb_qpsk_tx_framer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] frame_len = 8'h00;
    logic       mod_req = 1'b0;

    logic       srdy4, fr4, act4, done4, und4;
    logic [1:0] sym4;
    logic       srdy16, fr16, act16, done16, und16;
    logic [1:0] sym16;

    int checks = 0;
    int errors = 0;
    int dcnt4 = 0;

    always #5 clk = ~clk;
    always @(negedge clk) if (done4) dcnt4++;

    qpsk_tx_framer #(.PREAMBLE_SYMS(4)) dut4 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(srdy4),
        .frame_start(frame_start), .frame_len(frame_len), .frame_ready(fr4),
        .mod_req(mod_req), .symbol_out(sym4), .tx_active(act4), .frame_done(done4),
        .underrun_err(und4)
    );

    qpsk_tx_framer dut16 (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(srdy16),
        .frame_start(frame_start), .frame_len(frame_len), .frame_ready(fr16),
        .mod_req(mod_req), .symbol_out(sym16), .tx_active(act16), .frame_done(done16),
        .underrun_err(und16)
    );

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; s_valid = 1'b0; frame_start = 1'b0; mod_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic req(input int gap);
        repeat (gap) @(negedge clk);
        mod_req = 1'b1;
        @(negedge clk);
        mod_req = 1'b0;
    endtask

    task automatic wr(input logic [7:0] b);
        @(negedge clk);
        s_valid = 1'b1; s_data = b;
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic start(input logic [7:0] len);
        @(negedge clk);
        frame_start = 1'b1; frame_len = len;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sym16 !== 2'b00) begin errors++; $display("FAIL reset_sym got %b want 00", sym16); end
        checks++; if (act16 !== 1'b0) begin errors++; $display("FAIL reset_active got %b want 0", act16); end
        checks++; if (fr16 !== 1'b1) begin errors++; $display("FAIL reset_frame_ready got %b want 1", fr16); end
        checks++; if (srdy16 !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", srdy16); end
        checks++; if (und16 !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", und16); end
        checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done16); end
    endtask

    task automatic test_basic();
        logic [55:0] seq;
        int d0;
        seq = 56'b00110011_1101001110010001_00000010_1010010100111100_10011001;
        do_reset();
        wr(8'hA5);
        wr(8'h3C);
        start(8'd2);
        d0 = dcnt4;
        checks++; if (act4 !== 1'b1 || fr4 !== 1'b0) begin errors++; $display("FAIL basic_start act=%b rdy=%b want 1 0", act4, fr4); end
        checks++; if (sym4 !== seq[55:54]) begin errors++; $display("FAIL basic_sym0 got %b want %b", sym4, seq[55:54]); end
        for (int k = 1; k < 28; k++) begin
            req(99);
            checks++;
            if (sym4 !== seq[55-2*k -: 2]) begin errors++; $display("FAIL basic_sym%0d got %b want %b", k, sym4, seq[55-2*k -: 2]); end
        end
        checks++; if (dcnt4 != d0) begin errors++; $display("FAIL basic_early_done got %0d pulses want 0", dcnt4 - d0); end
        req(99);
        checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL basic_done got %b want 1", done4); end
        checks++; if (act4 !== 1'b0 || fr4 !== 1'b1 || sym4 !== 2'b00) begin errors++; $display("FAIL basic_end act=%b rdy=%b sym=%b want 0 1 00", act4, fr4, sym4); end
        repeat (3) @(negedge clk);
        checks++; if (dcnt4 - d0 != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", dcnt4 - d0); end
    endtask

    task automatic test_len0();
        logic [15:0] sw;
        logic [1:0]  e;
        sw = 16'hD391;
        do_reset();
        // frame_start with a simultaneous mod_req: the request must be ignored
        @(negedge clk);
        frame_start = 1'b1; frame_len = 8'd0; mod_req = 1'b1;
        @(negedge clk);
        frame_start = 1'b0; mod_req = 1'b0;
        checks++; if (sym16 !== 2'b00 || act16 !== 1'b1) begin errors++; $display("FAIL len0_start sym=%b act=%b want 00 1", sym16, act16); end
        for (int k = 1; k < 32; k++) begin
            req(2);
            if (k < 16)      e = k[0] ? 2'b11 : 2'b00;
            else if (k < 24) e = sw[15-2*(k-16) -: 2];
            else             e = 2'b00;
            checks++;
            if (sym16 !== e) begin errors++; $display("FAIL len0_sym%0d got %b want %b", k, sym16, e); end
            if (k == 31) begin
                checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL len0_early_done got %b want 0", done16); end
            end
        end
        req(2);
        checks++; if (done16 !== 1'b1 || act16 !== 1'b0) begin errors++; $display("FAIL len0_end done=%b act=%b want 1 0", done16, act16); end
    endtask

    task automatic test_underrun();
        do_reset();
        start(8'd1);
        for (int k = 0; k < 27; k++) req(1);
        checks++; if (sym16 !== 2'b01 || und16 !== 1'b0) begin errors++; $display("FAIL und_lastlen sym=%b und=%b want 01 0", sym16, und16); end
        req(1);
        checks++; if (sym16 !== 2'b01) begin errors++; $display("FAIL und_hold got %b want 01", sym16); end
        checks++; if (und16 !== 1'b1 || act16 !== 1'b1) begin errors++; $display("FAIL und_flag und=%b act=%b want 1 1", und16, act16); end
        wr(8'hFF);
        for (int k = 0; k < 8; k++) begin
            req(1);
            checks++;
            if (sym16 !== 2'b11) begin errors++; $display("FAIL und_sym%0d got %b want 11", k, sym16); end
        end
        req(1);
        checks++; if (done16 !== 1'b1 || und16 !== 1'b1) begin errors++; $display("FAIL und_end done=%b und=%b want 1 1", done16, und16); end
    endtask

    task automatic test_full();
        logic [7:0] b;
        logic [7:0] ck;
        logic [1:0] e;
        ck = 8'h00;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wr(8'(i * 17) ^ 8'h5A);
            if (i == 14) begin
                checks++; if (srdy16 !== 1'b1) begin errors++; $display("FAIL full_15 s_ready got %b want 1", srdy16); end
            end
        end
        checks++; if (srdy16 !== 1'b0) begin errors++; $display("FAIL full_16 s_ready got %b want 0", srdy16); end
        start(8'd16);
        for (int k = 0; k < 27; k++) req(1);
        checks++; if (srdy16 !== 1'b0) begin errors++; $display("FAIL full_prepop s_ready got %b want 0", srdy16); end
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 17) ^ 8'h5A;
            ck = ck ^ b;
            for (int j = 0; j < 4; j++) begin
                req(1);
                e = b[7-2*j -: 2];
                checks++;
                if (sym16 !== e) begin errors++; $display("FAIL full_b%0d_s%0d got %b want %b", i, j, sym16, e); end
                if (i == 0 && j == 0) begin
                    checks++; if (srdy16 !== 1'b1) begin errors++; $display("FAIL full_postpop s_ready got %b want 1", srdy16); end
                end
            end
        end
        for (int j = 0; j < 4; j++) begin
            req(1);
            e = ck[7-2*j -: 2];
            checks++;
            if (sym16 !== e) begin errors++; $display("FAIL full_ck%0d got %b want %b", j, sym16, e); end
        end
        req(1);
        checks++; if (done16 !== 1'b1 || und16 !== 1'b0) begin errors++; $display("FAIL full_end done=%b und=%b want 1 0", done16, und16); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(8'h12);
        wr(8'h34);
        start(8'd2);
        for (int k = 0; k < 29; k++) req(1);
        checks++; if (act16 !== 1'b1) begin errors++; $display("FAIL mid_active got %b want 1", act16); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (sym16 !== 2'b00 || act16 !== 1'b0 || fr16 !== 1'b1) begin errors++; $display("FAIL mid_reset sym=%b act=%b rdy=%b want 00 0 1", sym16, act16, fr16); end
        checks++; if (srdy16 !== 1'b1 || und16 !== 1'b0 || done16 !== 1'b0) begin errors++; $display("FAIL mid_reset_flags srdy=%b und=%b done=%b want 1 0 0", srdy16, und16, done16); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start(8'd1);
        checks++; if (sym16 !== 2'b00 || act16 !== 1'b1) begin errors++; $display("FAIL mid_restart sym=%b act=%b want 00 1", sym16, act16); end
        for (int k = 0; k < 28; k++) req(1);
        checks++; if (und16 !== 1'b1 || sym16 !== 2'b01) begin errors++; $display("FAIL mid_fifo_flushed und=%b sym=%b want 1 01", und16, sym16); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len0();
        test_underrun();
        test_full();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/qpsk_tx_framer.md
Name: qpsk_tx_framer

Overview:
- Transmit-side symbol source for qpsk_modulator; answers the modulator's mod_req symbol-request handshake.
- Accepts payload bytes on a valid/ready stream into an internal FIFO.
- On frame_start, emits one frame as 2-bit symbols: preamble, sync word, length, payload, XOR checksum.
- This is exactly the frame structure the receive path (ADC, qpsk_demodulator, deframer) will parse.

Parameters:
PREAMBLE_SYMS, 16, number of preamble symbols; must be even and >= 2
SYNC_WORD, 16'hD391, frame sync pattern, sent MSB first
FIFO_DEPTH, 16, payload byte FIFO entries; must be a power of 2

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
s_data  input  8  payload byte
s_valid  input  1  s_data valid
s_ready  output  1  FIFO can accept a byte
frame_start  input  1  request a new frame, single-cycle pulse
frame_len  input  8  payload byte count, sampled with frame_start
frame_ready  output  1  framer idle; frame_start will be accepted
mod_req  input  1  modulator requests the next symbol, single-cycle pulse
symbol_out  output  2  current symbol to modulator symbol_in
tx_active  output  1  frame in progress; drives modulator symbol_en
frame_done  output  1  one-cycle pulse after the last symbol is consumed
underrun_err  output  1  sticky flag: payload byte needed while FIFO empty

Behaviour:
- Reset (async, active-low): FIFO emptied, state IDLE. Outputs: symbol_out=2'b00, tx_active=0, frame_done=0, underrun_err=0, frame_ready=1, s_ready=1.
- FIFO write: s_valid && s_ready writes s_data. s_ready = FIFO not full.
  - Writes are accepted in any state.
  - There is no write-to-read bypass; a byte is poppable the cycle after it is written.
  - Bytes beyond frame_len stay queued for the next frame.
- Symbol mapping: every byte and the sync word are sent MSB pair first. A byte is sent as bits[7:6], [5:4], [3:2], [1:0].
- States: IDLE -> PREAMBLE -> SYNC (8 symbols) -> LEN (4) -> PAYLOAD (4*frame_len) -> CKSUM (4) -> IDLE.
  - PAYLOAD is skipped when frame_len=0.
- IDLE: frame_ready=1. frame_start loads the length register, clears the checksum and underrun_err, and enters PREAMBLE.
  - On that same edge: symbol_out=2'b00, tx_active=1, frame_ready=0.
  - frame_start in any other state is ignored.
- Handshake: symbol_out always holds the current symbol. Each mod_req cycle advances to the next symbol, registered on that edge. With no mod_req, symbol_out holds.
- Preamble: alternates 2'b00, 2'b11, starting with 2'b00.
- Checksum: XOR of all payload bytes, updated as each byte is popped. It is 8'h00 for frame_len=0.
- Payload pop: the FIFO is popped when advancing onto the first symbol of each payload byte.
  - If the FIFO is empty at that point: hold state and symbol_out, set underrun_err, and retry on the next mod_req.
- End of frame: mod_req while showing the last CKSUM symbol causes, on that edge:
  - tx_active=0, frame_done=1 for one cycle, symbol_out=2'b00, frame_ready=1.
- Total symbols per frame = PREAMBLE_SYMS + 16 + 4*frame_len, excluding underrun repeats.
- mod_req while IDLE: ignored. mod_req and frame_start in the same IDLE cycle: the frame starts and that mod_req is ignored.
- Reset mid-frame: immediate return to reset values, with FIFO contents discarded.

Test Plan:
- Reset asserted then released -> symbol_out=00, tx_active=0, frame_ready=1, s_ready=1, underrun_err=0.
- PREAMBLE_SYMS=4. Preload bytes 0xA5, 0x3C, then frame_start with frame_len=2, then 28 mod_req pulses spaced 100 cycles apart -> symbol_out sequence:
  - 00 11 00 11 (preamble)
  - 11 01 00 11 10 01 00 01 (sync)
  - 00 00 00 10 (length)
  - 10 10 01 01 and 00 11 11 00 (payload)
  - 10 01 10 01 (checksum 0x99)
  - frame_done pulses once, on the 28th mod_req edge, then tx_active=0.
- frame_len=0 with default parameters -> 32 symbols; last 4 are 00 00 00 00; frame_done pulses after the 32nd mod_req.
- frame_len=1 with the FIFO empty -> after the last LEN symbol, the next mod_req holds symbol_out and sets underrun_err.
  - Writing 0xFF then sending mod_req -> symbols 11 11 11 11, then checksum 11 11 11 11.
- Write 16 bytes while IDLE -> s_ready=0 after the 16th write. frame_start with frame_len=16 -> s_ready returns 1 after the first payload pop; all 16 bytes are sent in order.
- Reset asserted during PAYLOAD -> outputs immediately at reset values and FIFO empty. A subsequent frame_len=1 frame starts cleanly with preamble symbol 00.
